// File: rtl/timed_flag_write_pkg.sv
// Shared types and constants for the timed flag capture unit.
// Holds the drain state encoding, the capacity derivation and the byte strobe pattern.
package timed_flag_write_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } drain_state_t;

   // Wide enough for any supported data width; users slice the low bits.
   localparam logic [127:0] STRB_ONES = '1;

   function automatic int cap_of(input int len_w);
      return 32'sd1 << len_w;
   endfunction

endpackage

// File: rtl/timed_flag_drainer.sv
// Drain engine: reads captured timestamps from the idle half of the ping-pong memory
// and sends them as one databus write burst, one beat every two cycles.
module timed_flag_drainer
   import timed_flag_write_pkg::*;
#(
   parameter int AXI_DATA_W = 32,
   parameter int ADDR_W     = 16,
   parameter int LEN_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    go,
   input  logic                    pp,
   input  logic [LEN_W:0]          drain_cnt,
   output logic                    idle,
   input  logic                    databus_ready,
   input  logic                    databus_last,
   output logic                    databus_valid,
   output logic [AXI_DATA_W-1:0]   databus_wdata,
   output logic [AXI_DATA_W/8-1:0] databus_wstrb,
   output logic [ADDR_W-1:0]       port_1_addr,
   output logic [AXI_DATA_W-1:0]   port_1_out,
   input  logic [AXI_DATA_W-1:0]   port_1_in,
   output logic                    port_1_enable,
   output logic                    port_1_write
);

   localparam logic [LEN_W:0] ONE_C = (LEN_W+1)'(1);

   drain_state_t          state;
   drain_state_t          state_next;
   logic [LEN_W-1:0]      rd_idx;
   logic                  first_beat;
   logic [AXI_DATA_W-1:0] hold_data;
   logic [AXI_DATA_W-1:0] send_data;
   logic                  handshake;
   logic                  final_beat;

   assign handshake  = (state == ST_SEND) && databus_ready;
   assign final_beat = databus_last || ({1'b0, rd_idx} == (drain_cnt - ONE_C));

   // Drain state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a started burst always runs to completion.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (go) state_next = ST_FETCH;
            else    state_next = ST_IDLE;
         end
         ST_FETCH: state_next = ST_SEND;
         ST_SEND: begin
            if (databus_ready) state_next = final_beat ? ST_IDLE : ST_FETCH;
            else               state_next = ST_SEND;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Read index and a copy of the fetched word so wdata holds while the bus stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_idx     <= '0;
         first_beat <= 1'b0;
         hold_data  <= '0;
      end else begin
         first_beat <= (state == ST_FETCH);
         if (first_beat) hold_data <= port_1_in;
         if (load)           rd_idx <= '0;
         else if (handshake) rd_idx <= rd_idx + 1'b1;
      end
   end

   assign send_data     = first_beat ? port_1_in : hold_data;
   assign idle          = (state == ST_IDLE);
   assign databus_valid = (state == ST_SEND);
   assign databus_wdata = databus_valid ? send_data : '0;
   assign databus_wstrb = databus_valid ? STRB_ONES[AXI_DATA_W/8-1:0] : '0;
   assign port_1_addr   = {~pp, (ADDR_W-1)'(rd_idx)};
   assign port_1_out    = '0;
   assign port_1_enable = (state == ST_FETCH);
   assign port_1_write  = 1'b0;

endmodule

// File: rtl/timed_flag_write.sv
// Timed flag capture unit: timestamps nonzero in0 cycles into one ping-pong half
// while the other half is drained to external memory on each run pulse.
module timed_flag_write
   import timed_flag_write_pkg::*;
#(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int ADDR_W     = 16,
   parameter int LEN_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    running,
   input  logic                    run,
   output logic                    done,
   input  logic                    databus_ready_0,
   output logic                    databus_valid_0,
   output logic [AXI_ADDR_W-1:0]   databus_addr_0,
   input  logic [AXI_DATA_W-1:0]   databus_rdata_0,
   output logic [AXI_DATA_W-1:0]   databus_wdata_0,
   output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
   output logic [LEN_W-1:0]        databus_len_0,
   input  logic                    databus_last_0,
   output logic [ADDR_W-1:0]       ext_dp_addr_0_port_0,
   output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_0,
   input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_0,
   output logic                    ext_dp_enable_0_port_0,
   output logic                    ext_dp_write_0_port_0,
   output logic [ADDR_W-1:0]       ext_dp_addr_0_port_1,
   output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_1,
   input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_1,
   output logic                    ext_dp_enable_0_port_1,
   output logic                    ext_dp_write_0_port_1,
   input  logic [AXI_ADDR_W-1:0]   ext_addr,
   input  logic [31:0]             delay0,
   input  logic                    disabled,
   input  logic [31:0]             in0,
   output logic [31:0]             out0
);

   localparam int             CAP   = cap_of(LEN_W);
   localparam logic [LEN_W:0] CAP_C = (LEN_W+1)'(CAP);
   localparam logic [LEN_W:0] ONE_C = (LEN_W+1)'(1);

   logic           pp;
   logic [31:0]    cycle;
   logic [LEN_W:0] cnt;
   logic [LEN_W:0] drain_cnt;
   logic [31:0]    delay;
   logic           drain_idle;
   logic           run_accept;
   logic           capture_en;
   logic           event_write;
   logic           go;
   logic           unused_ok;

   assign unused_ok   = ^{databus_rdata_0, ext_dp_in_0_port_0};
   assign run_accept  = run && drain_idle;
   assign capture_en  = running && !disabled && !run;
   assign event_write = capture_en && (delay == 32'd0) && (in0 != 32'd0) && (cnt < CAP_C);
   assign go          = run_accept && (cnt != '0) && !disabled;

   // Ping-pong swap on accepted runs, otherwise delay countdown and event capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pp             <= 1'b0;
         cycle          <= 32'd0;
         cnt            <= '0;
         drain_cnt      <= '0;
         delay          <= 32'd0;
         databus_addr_0 <= '0;
      end else if (run_accept) begin
         pp             <= ~pp;
         drain_cnt      <= cnt;
         cnt            <= '0;
         cycle          <= 32'd0;
         delay          <= delay0;
         databus_addr_0 <= ext_addr;
      end else if (capture_en) begin
         if (delay != 32'd0) begin
            delay <= delay - 32'd1;
         end else begin
            cycle <= cycle + 32'd1;
            if (event_write) cnt <= cnt + ONE_C;
         end
      end
   end

   // Entry count reported one cycle late, forced to zero while bypassed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0 <= 32'd0;
      end else begin
         out0 <= disabled ? 32'd0 : 32'(cnt);
      end
   end

   assign ext_dp_addr_0_port_0   = {pp, (ADDR_W-1)'(cnt)};
   assign ext_dp_out_0_port_0    = event_write ? cycle : '0;
   assign ext_dp_enable_0_port_0 = event_write;
   assign ext_dp_write_0_port_0  = event_write;
   assign databus_len_0          = LEN_W'(drain_cnt - ONE_C);
   assign done = !running || disabled || (drain_idle && (delay == 32'd0));

   timed_flag_drainer #(
      .AXI_DATA_W(AXI_DATA_W),
      .ADDR_W    (ADDR_W),
      .LEN_W     (LEN_W)
   ) u_drainer (
      .clk          (clk),
      .rst          (rst),
      .load         (run_accept),
      .go           (go),
      .pp           (pp),
      .drain_cnt    (drain_cnt),
      .idle         (drain_idle),
      .databus_ready(databus_ready_0),
      .databus_last (databus_last_0),
      .databus_valid(databus_valid_0),
      .databus_wdata(databus_wdata_0),
      .databus_wstrb(databus_wstrb_0),
      .port_1_addr  (ext_dp_addr_0_port_1),
      .port_1_out   (ext_dp_out_0_port_1),
      .port_1_in    (ext_dp_in_0_port_1),
      .port_1_enable(ext_dp_enable_0_port_1),
      .port_1_write (ext_dp_write_0_port_1)
   );

endmodule

// File: tb/tb_timed_flag_write.sv
// Directed bench for timed_flag_write with LEN_W = 2: capture, drain, backpressure,
// overflow, ignored mid-drain run, bypass and asynchronous reset.
module tb_timed_flag_write;

   logic        clk = 1'b0;
   logic        rst, running, run, done, ready, valid, last, disabled;
   logic [31:0] addr, rdata, wdata, ext_addr, delay0, in0, out0;
   logic [3:0]  wstrb;
   logic [1:0]  len;
   logic [15:0] a0, a1;
   logic [31:0] d0, q0, d1, q1;
   logic        en0, wr0, en1, wr1;

   logic [31:0] mem [0:65535];
   logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], beat_q[$];
   logic [31:0] baddr_q[$], blen_q[$], last_q[$], cap_d[$];
   int          burst_beat = 0, stab_err = 0, strb_err = 0;
   logic        pv = 1'b0, pr = 1'b0;
   logic [31:0] pw = 32'd0;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   assign rdata = 32'd0;
   assign q0    = 32'd0;
   assign last  = valid && (burst_beat == int'(len));

   timed_flag_write #(
      .AXI_ADDR_W(32), .AXI_DATA_W(32), .ADDR_W(16), .LEN_W(2)
   ) dut (
      .clk(clk), .rst(rst), .running(running), .run(run), .done(done),
      .databus_ready_0(ready), .databus_valid_0(valid), .databus_addr_0(addr),
      .databus_rdata_0(rdata), .databus_wdata_0(wdata), .databus_wstrb_0(wstrb),
      .databus_len_0(len), .databus_last_0(last),
      .ext_dp_addr_0_port_0(a0), .ext_dp_out_0_port_0(d0), .ext_dp_in_0_port_0(q0),
      .ext_dp_enable_0_port_0(en0), .ext_dp_write_0_port_0(wr0),
      .ext_dp_addr_0_port_1(a1), .ext_dp_out_0_port_1(d1), .ext_dp_in_0_port_1(q1),
      .ext_dp_enable_0_port_1(en1), .ext_dp_write_0_port_1(wr1),
      .ext_addr(ext_addr), .delay0(delay0), .disabled(disabled), .in0(in0), .out0(out0)
   );

   // Memory model plus bus monitor: logs writes, reads, beats and stall stability.
   always @(posedge clk) begin
      if (en0 && wr0) begin
         mem[a0] <= d0;
         wr_addr_q.push_back(32'(a0));
         wr_data_q.push_back(d0);
      end
      if (en1) begin
         q1 <= mem[a1];
         rd_addr_q.push_back(32'(a1));
      end
      if (rst) begin
         burst_beat <= 0;
      end else if (valid && ready) begin
         beat_q.push_back(wdata);
         if (wstrb != 4'hF) strb_err <= strb_err + 1;
         if (burst_beat == 0) begin
            baddr_q.push_back(addr);
            blen_q.push_back(32'(len));
         end
         if (last) begin
            last_q.push_back(32'(burst_beat));
            burst_beat <= 0;
         end else begin
            burst_beat <= burst_beat + 1;
         end
      end
      if (!rst && pv && !pr && (!valid || wdata != pw)) stab_err <= stab_err + 1;
      pv <= valid && !rst;
      pr <= ready;
      pw <= wdata;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); beat_q.delete();
      baddr_q.delete(); blen_q.delete(); last_q.delete();
   endtask

   task automatic pulse_run();
      @(negedge clk) run = 1'b1;
      @(negedge clk) run = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget);
      int i = 0;
      while (beat_q.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("beat_timeout", 32'(beat_q.size() >= n), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int i = 0;
      while (!valid && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("valid_timeout", 32'(valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1; running = 1'b0; run = 1'b0; ready = 1'b1; disabled = 1'b0;
      ext_addr = 32'd0; delay0 = 32'd0; in0 = 32'd0;
      #12;
      chk("rst_done", 32'(done), 32'd1);
      chk("rst_out0", out0, 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      @(negedge clk) rst = 1'b0;
      running = 1'b1;

      // First run: delay 2, events on cycles 3, 5, 9 after the run pulse.
      delay0 = 32'd2;
      @(negedge clk) run = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         run = 1'b0;
         in0 = (k == 3 || k == 5 || k == 9) ? 32'd1 : 32'd0;
         #1;
         if (k == 1)  chk("delay_done", 32'(done), 32'd0);
         if (k == 10) chk("out0_lat", out0, 32'd2);
         if (k == 11) chk("out0_cnt", out0, 32'd3);
      end
      chk("r1_nwr", 32'(wr_addr_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("r1_addr", wr_addr_q[i], 32'h8000 + 32'(i));
      end
      chk("r1_d0", wr_data_q[0], 32'd0);
      chk("r1_d1", wr_data_q[1], 32'd2);
      chk("r1_d2", wr_data_q[2], 32'd6);
      chk("r1_nobus", 32'(beat_q.size()), 32'd0);

      // Second run drains to 0x1000 while two new events land in the other half.
      clear_logs();
      delay0 = 32'd0; ext_addr = 32'h1000;
      @(negedge clk) run = 1'b1;
      @(negedge clk) run = 1'b0; in0 = 32'd1;
      @(negedge clk) in0 = 32'd1;
      @(negedge clk) in0 = 32'd0;
      wait_beats(3, 40);
      repeat (2) @(negedge clk);
      chk("r2_addr", baddr_q[0], 32'h1000);
      chk("r2_len", blen_q[0], 32'd2);
      chk("r2_b0", beat_q[0], 32'd0);
      chk("r2_b1", beat_q[1], 32'd2);
      chk("r2_b2", beat_q[2], 32'd6);
      chk("r2_nbeat", 32'(beat_q.size()), 32'd3);
      chk("r2_last", last_q[0], 32'd2);
      for (int i = 0; i < 3; i++) begin
         chk("r2_raddr", rd_addr_q[i], 32'h8000 + 32'(i));
      end
      chk("r2_done", 32'(done), 32'd1);
      chk("r2_wdata_idle", wdata, 32'd0);
      chk("r2_wa0", wr_addr_q[0], 32'h0000);
      chk("r2_wa1", wr_addr_q[1], 32'h0001);
      chk("r2_wd1", wr_data_q[1], 32'd1);
      chk("r2_strb", 32'(strb_err), 32'd0);

      // Backpressure: ready held low for 5 cycles during SEND.
      clear_logs();
      ready = 1'b0;
      pulse_run();
      wait_valid(20);
      repeat (5) @(negedge clk);
      #1;
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_wdata", wdata, 32'd0);
      ready = 1'b1;
      wait_beats(2, 40);
      repeat (3) @(negedge clk);
      chk("bp_nbeat", 32'(beat_q.size()), 32'd2);
      chk("bp_b0", beat_q[0], 32'd0);
      chk("bp_b1", beat_q[1], 32'd1);
      chk("bp_ra1", rd_addr_q[1], 32'h0001);
      chk("bp_stable", 32'(stab_err), 32'd0);

      // Overflow: 10 events, only 4 fit.
      clear_logs();
      for (int k = 0; k < 10; k++) @(negedge clk) in0 = 32'hA5;
      @(negedge clk) in0 = 32'd0;
      repeat (2) @(negedge clk);
      chk("ov_nwr", 32'(wr_addr_q.size()), 32'd4);
      chk("ov_out0", out0, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("ov_addr", wr_addr_q[i], 32'h8000 + 32'(i));
         if (i > 0) chk("ov_seq", wr_data_q[i], wr_data_q[0] + 32'(i));
      end
      cap_d = wr_data_q;

      // Drain of the full half with a run pulse issued mid-burst.
      clear_logs();
      ext_addr = 32'h2000;
      pulse_run();
      ext_addr = 32'h3000;
      wait_beats(1, 40);
      run = 1'b1;
      @(negedge clk) run = 1'b0;
      wait_beats(4, 40);
      repeat (4) @(negedge clk);
      chk("ov_nbeat", 32'(beat_q.size()), 32'd4);
      chk("ov_len", blen_q[0], 32'd3);
      chk("ov_last", last_q[0], 32'd3);
      chk("ov_baddr", addr, 32'h2000);
      for (int i = 0; i < 4; i++) chk("ov_beat", beat_q[i], cap_d[i]);
      wr_addr_q.delete();
      @(negedge clk) in0 = 32'd1;
      @(negedge clk) in0 = 32'd0;
      chk("mid_run_pp", wr_addr_q[0], 32'h0000);

      // Bypass: no capture, out0 forced to 0, done high.
      wr_addr_q.delete();
      disabled = 1'b1;
      for (int k = 0; k < 3; k++) @(negedge clk) in0 = 32'd1;
      @(negedge clk) in0 = 32'd0;
      repeat (2) @(negedge clk);
      chk("dis_nwr", 32'(wr_addr_q.size()), 32'd0);
      chk("dis_out0", out0, 32'd0);
      chk("dis_done", 32'(done), 32'd1);
      disabled = 1'b0;

      // Asynchronous reset while a beat is stalled in SEND.
      ready = 1'b0;
      pulse_run();
      wait_valid(20);
      #2 rst = 1'b1;
      #1 chk("arst_valid", 32'(valid), 32'd0);
      @(negedge clk) rst = 1'b0;
      ready = 1'b1;
      #1;
      chk("arst_done", 32'(done), 32'd1);
      chk("arst_out0", out0, 32'd0);
      repeat (2) @(negedge clk);
      chk("arst_idle", 32'(valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timed_flag_write.md
Name: timed_flag_write

Overview:
- Capture-side counterpart of the timed flag reader.
- During a run, it timestamps every cycle on which in0 is nonzero and records the timestamps into one half of a ping-pong external dual-port memory.
- On the next run pulse the halves swap. The filled half is then drained to external memory as a single databus write burst.
- Sits in the Versat accelerator as a unit with one databus master and one two-port ext_dp memory.

Parameters:
- AXI_ADDR_W, 32, databus address width
- AXI_DATA_W, 32, databus data width and stored entry width
- ADDR_W, 16, ext_dp address width; MSB selects the ping-pong half
- LEN_W, 8, databus burst length width; capacity per half CAP = 2^LEN_W entries, requires LEN_W <= ADDR_W-1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- running  in  1  accelerator active
- run  in  1  one-cycle start pulse
- done  out  1  unit idle
- databus_ready_0  in  1  write beat accepted
- databus_valid_0  out  1  write beat valid
- databus_addr_0  out  AXI_ADDR_W  burst base address
- databus_rdata_0  in  AXI_DATA_W  unused
- databus_wdata_0  out  AXI_DATA_W  beat data
- databus_wstrb_0  out  AXI_DATA_W/8  byte strobes
- databus_len_0  out  LEN_W  beats minus one
- databus_last_0  in  1  final beat of burst
- ext_dp_addr_0_port_0 / _out_ / _in_ / _enable_ / _write_  out/out/in/out/out  ADDR_W/AXI_DATA_W/AXI_DATA_W/1/1  capture write port
- ext_dp_addr_0_port_1 / _out_ / _in_ / _enable_ / _write_  out/out/in/out/out  ADDR_W/AXI_DATA_W/AXI_DATA_W/1/1  drain read port, 1-cycle read latency
- ext_addr  in  AXI_ADDR_W  destination address for the next drain
- delay0  in  32  cycles after run before capture starts
- disabled  in  1  unit bypass
- in0  in  32  event input; nonzero means event
- out0  out  32  entries captured so far in the current half (versat_latency = 1)

Behaviour:
- Reset state:
  - All registers are 0, including pp (ping-pong bit), cycle, cnt, drainCnt, delay, rdIdx and the FSM (IDLE).
  - databus_valid_0 = 0, out0 = 0, done = 1.
- run pulse, accepted only when the FSM is IDLE:
  - pp toggles.
  - drainCnt <= cnt; cnt <= 0; cycle <= 0; delay <= delay0.
  - databus_addr_0 <= ext_addr; rdIdx <= 0.
  - If drainCnt_next != 0 and !disabled, the FSM goes to FETCH on the next cycle.
- run pulse while the FSM is busy: ignored entirely, with no swap and no reloads. The drain completes untouched.
- Capture, only when running && !disabled && !run:
  - If delay != 0, delay decrements and nothing is captured.
  - Otherwise cycle increments each cycle.
  - If in0 != 0 and cnt < CAP: port_0 writes data = cycle (pre-increment value) at addr {pp, cnt[ADDR_W-2:0]}, with enable = write = 1, and cnt increments.
  - When cnt == CAP, further events are dropped and cnt saturates.
- out0 is registered: out0 = cnt (1-cycle latency). It is 0 while disabled.
- port_1 addresses {!pp, rdIdx}, with write = 0 and out = 0.
- Drain FSM, with constant databus_len_0 = drainCnt-1 truncated to LEN_W:
  - IDLE: no activity.
  - FETCH: port_1 enable = 1 for one cycle, then go to SEND.
  - SEND: databus_valid_0 = 1 and wdata = captured read data, held stable until ready.
  - On the valid&&ready handshake: rdIdx increments. If databus_last_0 or rdIdx == drainCnt-1, go to IDLE; otherwise go to FETCH.
  - Throughput is 1 beat per 2 cycles.
- wstrb is all ones when valid, 0 otherwise. wdata = 0 outside SEND.
- done = !running || disabled || (FSM == IDLE && delay == 0).
- disabled asserted mid-drain: the burst still completes, because a databus burst cannot be abandoned. done reads 1.
- Asynchronous rst mid-burst: returns to the reset state immediately, with valid dropped.

Decomposition:
- Shared package:
  - drain state encoding: IDLE, FETCH, SEND
  - CAP derivation from LEN_W
  - wstrb all-ones constant
- One natural sub-module, timed_flag_drainer: the FETCH/SEND FSM plus rdIdx, with databus and port_1 outputs.
- The top level keeps the ping-pong bit, delay, cycle counter and capture logic.

Test Plan:
- First run, delay0 = 2; in0 = 1 on cycles 3, 5 and 9 after run -> port_0 writes 0, 2, 6 at addrs 0x8000, 0x8001, 0x8002; out0 reads 3 one cycle after the last write; no databus traffic.
- Second run with ext_addr = 0x1000 -> addr 0x1000, len 2; beats 0, 2, 6 read from port_1 addrs 0x8000–0x8002; last on the third beat; done returns to 1.
- Bus backpressure: ready low for 5 cycles in SEND -> valid and wdata stay stable throughout; each beat is sent exactly once.
- Overflow with LEN_W = 2: in0 = 1 for 10 cycles -> only 4 entries written, out0 = 4; next drain len = 3.
- A run pulse mid-drain is ignored (pp is unchanged and the burst completes); disabled = 1 -> no port_0 writes, out0 = 0, done = 1.
- rst asserted during SEND -> valid drops asynchronously; after release, done = 1 and out0 = 0.
